// File: rtl/si_capture_buffer.sv
// Circular pre/post-trigger capture buffer between two simple-interface ports.
// Samples are kept in a ring RAM; the frozen window is replayed oldest-first.
module si_capture_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] SI_data,
  input  logic                  SI_rdy,
  output logic                  SI_ack,
  input  logic                  start_i,
  input  logic                  trigger_i,
  input  logic [ADDR_WIDTH-1:0] pretrigger,
  input  logic [ADDR_WIDTH:0]   num_samples,
  output logic [DATA_WIDTH-1:0] SO_data,
  output logic                  SO_rdy,
  input  logic                  SO_ack,
  output logic                  busy_o,
  output logic                  triggered_o,
  output logic                  done_o
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_W   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, FILL, WAIT_TRIG, POST, READ, DONE} state_t;
  state_t state_reg;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic [ADDR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg, start_addr_reg, p_reg;
  logic [ADDR_WIDTH:0]   n_reg, cnt_reg, words_left_reg;
  logic si_ack_reg, so_rdy_reg, load_reg, busy_reg, triggered_reg, done_reg;

  logic                  accept, capturing, wr_en, trig_hit, enter_read;
  logic                  so_take, last_take, rd_en;
  logic [ADDR_WIDTH-1:0] start_next, rd_addr;
  logic [ADDR_WIDTH:0]   n_clamp, p_clamp_w, post_len, cnt_inc;

  always_comb begin
    n_clamp = num_samples;
    if (num_samples == '0)
      n_clamp = ONE_W;
    else if (num_samples > DEPTH_W)
      n_clamp = DEPTH_W;
    p_clamp_w = {1'b0, pretrigger};
    if (p_clamp_w >= n_clamp)
      p_clamp_w = n_clamp - ONE_W;
  end

  assign accept     = SI_rdy && !si_ack_reg;
  assign capturing  = (state_reg == FILL) || (state_reg == WAIT_TRIG) || (state_reg == POST);
  assign wr_en      = accept && capturing;
  assign trig_hit   = accept && (state_reg == WAIT_TRIG) && trigger_i;
  assign post_len   = n_reg - {1'b0, p_reg};
  assign cnt_inc    = cnt_reg + ONE_W;
  assign enter_read = (trig_hit && post_len == ONE_W) ||
                      (accept && state_reg == POST && cnt_inc == post_len);
  assign start_next = (state_reg == WAIT_TRIG) ? wr_ptr_reg - p_reg : start_addr_reg;
  assign so_take    = (state_reg == READ) && so_rdy_reg && SO_ack;
  assign last_take  = so_take && (words_left_reg == ONE_W);
  assign rd_en      = enter_read || (so_take && !last_take);
  assign rd_addr    = enter_read ? start_next : rd_ptr_reg;

  always_ff @(posedge clk_i) begin
    if (wr_en)
      mem[wr_ptr_reg] <= SI_data;
  end

  // A one-word window reads the very address being written on the same edge,
  // so the incoming sample is forwarded around the RAM in that case.
  always_ff @(posedge clk_i) begin
    if (rst)
      rd_data_reg <= '0;
    else if (rd_en)
      rd_data_reg <= (wr_en && wr_ptr_reg == rd_addr) ? SI_data : mem[rd_addr];
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      start_addr_reg <= '0;
      p_reg          <= '0;
      n_reg          <= '0;
      cnt_reg        <= '0;
      words_left_reg <= '0;
      si_ack_reg     <= 1'b0;
      so_rdy_reg     <= 1'b0;
      load_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      triggered_reg  <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      si_ack_reg <= accept;
      done_reg   <= 1'b0;
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (enter_read) begin
        rd_ptr_reg     <= start_next + 1'b1;
        words_left_reg <= n_reg;
        load_reg       <= 1'b1;
      end
      case (state_reg)
        IDLE: if (start_i) begin
          n_reg     <= n_clamp;
          p_reg     <= p_clamp_w[ADDR_WIDTH-1:0];
          cnt_reg   <= '0;
          busy_reg  <= 1'b1;
          state_reg <= (p_clamp_w != '0) ? FILL : WAIT_TRIG;
        end
        FILL: if (accept) begin
          cnt_reg <= cnt_inc;
          if (cnt_inc == {1'b0, p_reg})
            state_reg <= WAIT_TRIG;
        end
        WAIT_TRIG: if (trig_hit) begin
          start_addr_reg <= start_next;
          triggered_reg  <= 1'b1;
          cnt_reg        <= ONE_W;
          state_reg      <= enter_read ? READ : POST;
        end
        POST: if (accept) begin
          cnt_reg <= cnt_inc;
          if (enter_read)
            state_reg <= READ;
        end
        READ: begin
          if (load_reg) begin
            so_rdy_reg <= 1'b1;
            load_reg   <= 1'b0;
          end else if (so_take) begin
            so_rdy_reg <= 1'b0;
            if (last_take) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              rd_ptr_reg     <= rd_ptr_reg + 1'b1;
              words_left_reg <= words_left_reg - ONE_W;
              load_reg       <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg     <= IDLE;
          busy_reg      <= 1'b0;
          triggered_reg <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign SI_ack      = si_ack_reg;
  assign SO_data     = rd_data_reg;
  assign SO_rdy      = so_rdy_reg;
  assign busy_o      = busy_reg;
  assign triggered_o = triggered_reg;
  assign done_o      = done_reg;
endmodule

// File: tb/tb_si_capture_buffer.sv
// Directed bench for si_capture_buffer with a 16-deep ring (ADDR_WIDTH=4).
// Producer streams 0,1,2,... after each start; consumer checks replayed words.
module tb_si_capture_buffer;
  logic       clk_i = 1'b0;
  logic       rst;
  logic [7:0] SI_data;
  logic       SI_rdy, SI_ack, start_i, trigger_i;
  logic [3:0] pretrigger;
  logic [4:0] num_samples;
  logic [7:0] SO_data;
  logic       SO_rdy, SO_ack, busy_o, triggered_o, done_o;

  int n_checks = 0;
  int n_errors = 0;

  si_capture_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk_i(clk_i), .rst(rst),
    .SI_data(SI_data), .SI_rdy(SI_rdy), .SI_ack(SI_ack),
    .start_i(start_i), .trigger_i(trigger_i),
    .pretrigger(pretrigger), .num_samples(num_samples),
    .SO_data(SO_data), .SO_rdy(SO_rdy), .SO_ack(SO_ack),
    .busy_o(busy_o), .triggered_o(triggered_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One capture: arm, stream samples, consume nwords starting at value first.
  task automatic run_capture(input string tag, input int n, input int p, input int t1,
                             input int t2, input int first, input int nwords,
                             input int ack_delay, input bit abort);
    int seq = 0, got_words = 0, wait_cnt = 0, cycles = 0, extra_done = 0;
    bit finished = 1'b0;
    logic [7:0] held = '0;
    @(negedge clk_i);
    SI_rdy = 1'b0; SO_ack = 1'b0;
    start_i = 1'b1; num_samples = n[4:0]; pretrigger = p[3:0];
    @(negedge clk_i);
    start_i = 1'b0;
    check({tag, "_busy"}, busy_o, 1);
    SI_data = 8'd0; trigger_i = (t1 == 0) || (t2 == 0); SI_rdy = 1'b1;
    while (!finished && cycles < 2000) begin
      @(negedge clk_i);
      cycles++;
      SO_ack = 1'b0;
      if (SI_ack) begin
        seq++;
        SI_data = seq[7:0];
        trigger_i = (seq == t1) || (seq == t2);
      end
      if (done_o) begin
        finished = 1'b1;
        check({tag, "_busy_in_done"}, busy_o, 1);
      end else if (SO_rdy) begin
        if (got_words == 0 && wait_cnt == 0)
          check({tag, "_triggered"}, triggered_o, 1);
        if (wait_cnt == 0)
          held = SO_data;
        else
          check({tag, "_stable"}, SO_data, held);
        if (abort) begin
          check({tag, "_word0"}, SO_data, first);
          rst = 1'b1;
          @(negedge clk_i);
          check({tag, "_abort_outs"}, {SO_rdy, busy_o, triggered_o, done_o}, 0);
          rst = 1'b0;
          $display("%s aborted in READ", tag);
          finished = 1'b1;
        end else if (wait_cnt >= ack_delay) begin
          $display("%s word %0d data=%0d", tag, got_words, SO_data);
          check({tag, "_word"}, SO_data, (first + got_words) & 8'hff);
          SO_ack = 1'b1;
          got_words++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
    check({tag, "_finished"}, finished, 1);
    if (!abort) begin
      check({tag, "_nwords"}, got_words, nwords);
      repeat (3) begin
        @(negedge clk_i);
        SO_ack = 1'b0;
        if (done_o) extra_done++;
      end
      check({tag, "_done_once"}, extra_done, 0);
      check({tag, "_idle"}, {busy_o, triggered_o, SO_rdy}, 0);
    end
  endtask

  initial begin
    rst = 1'b1; SI_rdy = 1'b1; SI_data = 8'h5a; start_i = 1'b0; trigger_i = 1'b0;
    pretrigger = '0; num_samples = '0; SO_ack = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check("rst_outs", {SI_ack, SO_rdy, busy_o, triggered_o, done_o, SO_data}, 0);
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      check("ack_toggle", SI_ack, (k % 2 == 0));
      check("idle_busy", busy_o, 0);
    end
    $display("reset sequence complete");

    run_capture("basic",     8,  3, 10, -1,  7,  8, 0, 1'b0);
    run_capture("wrap",     16, 15, 40, -1, 25, 16, 0, 1'b0);
    run_capture("early",     8,  4,  1,  6,  2,  8, 0, 1'b0);
    run_capture("clamp0",    0,  5,  3, -1,  3,  1, 0, 1'b0);
    run_capture("clampbig", 31,  4, 20, -1, 16, 16, 0, 1'b0);
    run_capture("pclamp",    4,  9, 10, -1,  7,  4, 0, 1'b0);
    run_capture("backpres",  8,  3, 10, -1,  7,  8, 5, 1'b0);
    run_capture("abort",     8,  3, 10, -1,  7,  8, 0, 1'b1);
    run_capture("restart",   8,  3, 10, -1,  7,  8, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
